// File: rtl/rr_arbiter3_atc.sv
// Three-way round-robin arbiter (A, B, C) with access-time control: a held grant
// is pre-empted after acc_time cycles when another processor is waiting.
module rr_arbiter3_atc #(
  parameter int TW      = 4,
  parameter int ACC_DEF = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          req_a,
  input  logic          req_b,
  input  logic          req_c,
  input  logic          acc_load,
  input  logic [TW-1:0] acc_val,
  output logic          gnt_a,
  output logic          gnt_b,
  output logic          gnt_c,
  output logic          busy,
  output logic          expire,
  output logic [TW-1:0] acc_time
);

  typedef enum logic [1:0] {IDLE, GNT_A, GNT_B, GNT_C} state_t;

  localparam logic [TW-1:0] ONE     = TW'(1);
  localparam logic [TW-1:0] ACC_RST = TW'(ACC_DEF);

  state_t        state, state_nxt;
  logic [1:0]    ptr, ptr_nxt;
  logic [1:0]    cur;
  logic [TW-1:0] timer, timer_nxt;
  logic [TW-1:0] pending_acc;
  logic [TW-1:0] eff_acc;
  logic [2:0]    req, own, sel;
  logic          enter, expire_nxt;

  function automatic logic [1:0] inc3(input logic [1:0] x);
    return (x == 2'd2) ? 2'd0 : x + 2'd1;
  endfunction

  // First requester strictly after 'after' in A->B->C->A order; bit 2 = found.
  function automatic logic [2:0] pick_next(input logic [1:0] after, input logic [2:0] r);
    logic [1:0] idx;
    logic [2:0] res;
    idx = after;
    res = 3'b000;
    for (int k = 0; k < 3; k++) begin
      idx = inc3(idx);
      if (!res[2] && r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  function automatic state_t gnt_state(input logic [1:0] idx);
    state_t s;
    case (idx)
      2'd0:    s = GNT_A;
      2'd1:    s = GNT_B;
      default: s = GNT_C;
    endcase
    return s;
  endfunction

  assign req     = {req_c, req_b, req_a};
  assign eff_acc = (acc_time == '0) ? ONE : acc_time;

  always_comb begin
    state_nxt  = state;
    ptr_nxt    = ptr;
    timer_nxt  = timer;
    expire_nxt = 1'b0;
    enter      = 1'b0;
    sel        = 3'b000;
    case (state)
      GNT_A:   cur = 2'd0;
      GNT_B:   cur = 2'd1;
      GNT_C:   cur = 2'd2;
      default: cur = ptr;
    endcase
    own = 3'b001 << cur;

    if (state == IDLE) begin
      sel = pick_next(ptr, req);
      if (sel[2]) begin
        state_nxt = gnt_state(sel[1:0]);
        timer_nxt = '0;
        enter     = 1'b1;
      end
    end else begin
      sel = pick_next(cur, req & ~own);
      if (!req[cur]) begin
        // Release hands straight to the next waiter, no idle bubble.
        state_nxt = sel[2] ? gnt_state(sel[1:0]) : IDLE;
        ptr_nxt   = cur;
        timer_nxt = '0;
        enter     = 1'b1;
      end else if (timer == eff_acc - ONE) begin
        timer_nxt = '0;
        if (sel[2]) begin
          state_nxt  = gnt_state(sel[1:0]);
          ptr_nxt    = cur;
          expire_nxt = 1'b1;
          enter      = 1'b1;
        end
      end else begin
        timer_nxt = timer + ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      ptr         <= 2'd2;
      timer       <= '0;
      expire      <= 1'b0;
      acc_time    <= ACC_RST;
      pending_acc <= ACC_RST;
    end else begin
      state  <= state_nxt;
      ptr    <= ptr_nxt;
      timer  <= timer_nxt;
      expire <= expire_nxt;
      if (acc_load) pending_acc <= acc_val;
      // A running slot keeps its limit; new value takes effect on slot/idle entry.
      if (state == IDLE || enter) acc_time <= acc_load ? acc_val : pending_acc;
    end
  end

  assign gnt_a = (state == GNT_A);
  assign gnt_b = (state == GNT_B);
  assign gnt_c = (state == GNT_C);
  assign busy  = gnt_a | gnt_b | gnt_c;

endmodule

// File: tb/tb_rr_arbiter3_atc.sv
// Directed, table-driven bench for rr_arbiter3_atc plus a hand-written
// asynchronous-reset sequence.
module tb_rr_arbiter3_atc;

  localparam int TW = 4;
  localparam logic [2:0] N = 3'b000, A = 3'b001, B = 3'b010, C = 3'b100;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          req_a = 1'b0, req_b = 1'b0, req_c = 1'b0;
  logic          acc_load = 1'b0;
  logic [TW-1:0] acc_val = '0;
  logic          gnt_a, gnt_b, gnt_c, busy, expire;
  logic [TW-1:0] acc_time;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [2:0]    req;
    logic          ld;
    logic [TW-1:0] val;
    logic [2:0]    gnt;
    logic          exp;
    logic [TW-1:0] acc;
  } vec_t;

  vec_t vecs[$];

  rr_arbiter3_atc #(.TW(TW), .ACC_DEF(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_a(req_a), .req_b(req_b), .req_c(req_c),
    .acc_load(acc_load), .acc_val(acc_val),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .gnt_c(gnt_c),
    .busy(busy), .expire(expire), .acc_time(acc_time)
  );

  always #5 clk = ~clk;

  task automatic add(input logic [2:0] r, input logic ld, input logic [TW-1:0] v,
                     input logic [2:0] g, input logic e, input logic [TW-1:0] a);
    vec_t t;
    t.req = r; t.ld = ld; t.val = v; t.gnt = g; t.exp = e; t.acc = a;
    vecs.push_back(t);
  endtask

  task automatic addn(input int n, input logic [2:0] r, input logic [2:0] g,
                      input logic [TW-1:0] a);
    for (int k = 0; k < n; k++) add(r, 1'b0, '0, g, 1'b0, a);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic check_outs(input string name, input logic [2:0] g, input logic e,
                            input logic [TW-1:0] a);
    check({name, "_gnt"}, {29'd0, gnt_c, gnt_b, gnt_a}, {29'd0, g});
    check({name, "_busy"}, {31'd0, busy}, {31'd0, |g});
    check({name, "_expire"}, {31'd0, expire}, {31'd0, e});
    check({name, "_acc"}, {28'd0, acc_time}, {28'd0, a});
  endtask

  task automatic drive(input logic [2:0] r, input logic ld, input logic [TW-1:0] v);
    {req_c, req_b, req_a} = r;
    acc_load = ld;
    acc_val  = v;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // NOREQ (pointer starts at C)
    addn(10, N, N, 4);
    // REQFA / REQFB / REQFC: lone requester never pre-empted
    addn(12, A, A, 4); addn(1, N, N, 4);
    addn(12, B, B, 4); addn(1, N, N, 4);
    addn(12, C, C, 4); addn(1, N, N, 4);
    // ATCAB: pointer C -> A first, 4-cycle slots
    addn(4, A|B, A, 4); add(A|B, 0, 0, B, 1, 4);
    addn(3, A|B, B, 4); add(A|B, 0, 0, A, 1, 4);
    addn(1, A|B, A, 4); addn(1, N, N, 4);
    // ATCBC: pointer A -> B first
    addn(4, B|C, B, 4); add(B|C, 0, 0, C, 1, 4);
    addn(3, B|C, C, 4); add(B|C, 0, 0, B, 1, 4);
    addn(1, N, N, 4);
    // ATCCA: pointer B -> C first
    addn(4, C|A, C, 4); add(C|A, 0, 0, A, 1, 4);
    addn(3, C|A, A, 4); add(C|A, 0, 0, C, 1, 4);
    addn(1, N, N, 4);
    // SACC: load 2 mid-slot, current slot keeps 4
    add(A|B, 0, 0, A, 0, 4); add(A|B, 1, 2, A, 0, 4);
    addn(2, A|B, A, 4);
    add(A|B, 0, 0, B, 1, 2); add(A|B, 0, 0, B, 0, 2);
    add(A|B, 0, 0, A, 1, 2); add(A|B, 0, 0, A, 0, 2);
    add(A|B, 0, 0, B, 1, 2);
    // acc_val=0 behaves as 1-cycle slots
    add(A|B, 1, 0, B, 0, 2);
    add(A|B, 0, 0, A, 1, 0); add(A|B, 0, 0, B, 1, 0);
    add(A|B, 0, 0, A, 1, 0); add(A|B, 0, 0, B, 1, 0);
    add(N, 0, 0, N, 0, 0);
    // Load while idle takes effect next edge
    add(N, 1, 4, N, 0, 4);
    // Release with another waiting: direct handoff, no bubble
    add(A, 0, 0, A, 0, 4); add(B, 0, 0, B, 0, 4);
    add(C, 0, 0, C, 0, 4); add(N, 0, 0, N, 0, 4);
    // Rotation skips B on timeout
    add(A, 0, 0, A, 0, 4); addn(3, A|C, A, 4);
    add(A|C, 0, 0, C, 1, 4); add(C, 0, 0, C, 0, 4);
    add(N, 0, 0, N, 0, 4);
    // Back-to-back loads in idle and during a slot: last wins
    add(N, 1, 7, N, 0, 7); add(N, 1, 3, N, 0, 3);
    add(A, 0, 0, A, 0, 3); add(A, 1, 9, A, 0, 3);
    add(A, 1, 2, A, 0, 3); add(A, 0, 0, A, 0, 3);
    add(N, 0, 0, N, 0, 2);

    // Reset
    #1 reset_n = 1'b0;
    #1 check_outs("rst_async", N, 1'b0, 4);
    step();
    step();
    check_outs("rst_hold", N, 1'b0, 4);
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].req, vecs[i].ld, vecs[i].val);
      step();
      check_outs($sformatf("v%0d", i), vecs[i].gnt, vecs[i].exp, vecs[i].acc);
    end

    // Reset mid gnt_b: grant drops without a clock edge
    drive(B, 1'b0, '0);
    step();
    check_outs("midrst_pre", B, 1'b0, 2);
    #2 reset_n = 1'b0;
    #1 check_outs("midrst_async", N, 1'b0, 4);
    drive(A|B|C, 1'b0, '0);
    step();
    check_outs("midrst_hold", N, 1'b0, 4);
    reset_n = 1'b1;
    step();
    check_outs("midrst_first", A, 1'b0, 4);
    step(); step(); step();
    check_outs("midrst_a4", A, 1'b0, 4);
    step();
    check_outs("midrst_b", B, 1'b1, 4);
    drive(N, 1'b0, '0);
    step();
    check_outs("midrst_idle", N, 1'b0, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
